// File: rtl/car_sensor_qualifier_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | car_sensor_qualifier_if                                          |
// | Shared sensor type and the qualifier's detector/controller bus.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+

package shared_pkg;
  typedef enum logic {
    NO_CARS = 1'b0,
    CARS    = 1'b1
  } sensor_state_e;
endpackage

interface car_sensor_qualifier_if #(
  parameter int GLITCH_W = 8
);
  import shared_pkg::*;

  logic                sensor_raw;
  logic                enable;
  logic                req_ack;
  sensor_state_e       sensor_state;
  logic                car_req;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output sensor_raw, enable, req_ack,
    input  sensor_state, car_req, glitch_cnt
  );

  modport slave (
    input  sensor_raw, enable, req_ack,
    output sensor_state, car_req, glitch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/car_sensor_qualifier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | car_sensor_qualifier                                             |
// | Synchronises/debounces the car detector, latches a sticky        |
// | request and counts aborted confirmations.                        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+

module car_sensor_qualifier
  import shared_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  car_sensor_qualifier_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    c_last_cnt   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    c_one        = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] c_glitch_max = '1;

  typedef enum logic [1:0] {
    S_NO_CARS     = 2'd0,
    S_CONFIRM_CAR = 2'd1,
    S_CARS        = 2'd2,
    S_CONFIRM_CLR = 2'd3
  } state_e;

  logic                r_sync_1;
  logic                r_sync_q;
  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_glitch;
  logic                r_car_req;
  logic                w_car_req_nxt;
  logic [GLITCH_W-1:0] r_glitch_cnt;
  logic                w_cur_cars;
  logic                w_nxt_cars;

  // Synchroniser keeps sampling even while disabled so re-enable sees a settled level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync_1 <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync_1 <= bus.sensor_raw;
      r_sync_q <= r_sync_1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_NO_CARS;
      r_cnt        <= '0;
      r_car_req    <= 1'b0;
      r_glitch_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_car_req <= w_car_req_nxt;
      if (w_glitch && (r_glitch_cnt != c_glitch_max))
        r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_glitch    = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = S_NO_CARS;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_NO_CARS: begin
          if (r_sync_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_state_nxt = S_CARS;
            end else begin
              w_state_nxt = S_CONFIRM_CAR;
              w_cnt_nxt   = c_one;
            end
          end
        end
        S_CONFIRM_CAR: begin
          if (!r_sync_q) begin
            w_state_nxt = S_NO_CARS;
            w_cnt_nxt   = '0;
            w_glitch    = 1'b1;
          end else if (r_cnt == c_last_cnt) begin
            w_state_nxt = S_CARS;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
        S_CARS: begin
          if (!r_sync_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_state_nxt = S_NO_CARS;
            end else begin
              w_state_nxt = S_CONFIRM_CLR;
              w_cnt_nxt   = c_one;
            end
          end
        end
        S_CONFIRM_CLR: begin
          if (r_sync_q) begin
            w_state_nxt = S_CARS;
            w_cnt_nxt   = '0;
            w_glitch    = 1'b1;
          end else if (r_cnt == c_last_cnt) begin
            w_state_nxt = S_NO_CARS;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
        default: begin
          w_state_nxt = S_NO_CARS;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A new arrival outranks a simultaneous acknowledge.
  assign w_cur_cars    = (r_state == S_CARS) || (r_state == S_CONFIRM_CLR);
  assign w_nxt_cars    = (w_state_nxt == S_CARS) || (w_state_nxt == S_CONFIRM_CLR);
  assign w_car_req_nxt = bus.enable &&
                         ((!w_cur_cars && w_nxt_cars) || (r_car_req && !bus.req_ack));

  assign bus.sensor_state = w_cur_cars ? CARS : NO_CARS;
  assign bus.car_req      = r_car_req;
  assign bus.glitch_cnt   = r_glitch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_car_sensor_qualifier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_car_sensor_qualifier                                          |
// | Directed bench for the car sensor qualifier (D=4, GLITCH_W=8).   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+

module tb_car_sensor_qualifier;
  import shared_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  car_sensor_qualifier_if #(.GLITCH_W(8)) bus ();

  car_sensor_qualifier #(
    .DEBOUNCE_CYCLES (4),
    .GLITCH_W        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.sensor_raw = 1'b0;
    bus.enable     = 1'b1;
    bus.req_ack    = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.sensor_raw = 1'b1;
    bus.enable     = 1'b1;
    bus.req_ack    = 1'b0;

    // Reset held with the detector already high
    step(1);
    check("rst_state", bus.sensor_state, NO_CARS);
    check("rst_req", bus.car_req, 0);
    check("rst_glitch", bus.glitch_cnt, 0);
    step(1);
    rst_n = 1'b1;
    step(5);
    check("lat_edge5_state", bus.sensor_state, NO_CARS);
    check("lat_edge5_req", bus.car_req, 0);
    step(1);
    check("lat_edge6_state", bus.sensor_state, CARS);
    check("lat_edge6_req", bus.car_req, 1);

    // Request stays until acknowledged
    step(20);
    check("req_hold", bus.car_req, 1);
    bus.req_ack = 1'b1;
    step(1);
    bus.req_ack = 1'b0;
    check("ack_clear", bus.car_req, 0);
    check("ack_state", bus.sensor_state, CARS);

    // Short clear glitch, then a real clear
    bus.sensor_raw = 1'b0;
    step(2);
    bus.sensor_raw = 1'b1;
    step(6);
    check("clr_glitch_state", bus.sensor_state, CARS);
    check("clr_glitch_cnt", bus.glitch_cnt, 1);
    bus.sensor_raw = 1'b0;
    step(5);
    check("clr_edge5", bus.sensor_state, CARS);
    step(1);
    check("clr_edge6", bus.sensor_state, NO_CARS);
    check("clr_req", bus.car_req, 0);

    // Glitch counter increments and saturates
    do_reset();
    bus.sensor_raw = 1'b1;
    step(3);
    bus.sensor_raw = 1'b0;
    step(3);
    check("glitch_first_state", bus.sensor_state, NO_CARS);
    check("glitch_first_cnt", bus.glitch_cnt, 1);
    for (int i = 0; i < 299; i++) begin
      bus.sensor_raw = 1'b1;
      step(3);
      bus.sensor_raw = 1'b0;
      step(3);
    end
    check("glitch_sat", bus.glitch_cnt, 255);
    check("glitch_sat_state", bus.sensor_state, NO_CARS);
    check("glitch_sat_req", bus.car_req, 0);
    bus.sensor_raw = 1'b1;
    step(3);
    bus.sensor_raw = 1'b0;
    step(3);
    check("glitch_sat_hold", bus.glitch_cnt, 255);

    // Acknowledge coinciding with the arrival edge
    do_reset();
    bus.sensor_raw = 1'b1;
    step(5);
    bus.req_ack = 1'b1;
    step(1);
    bus.req_ack = 1'b0;
    check("set_wins_state", bus.sensor_state, CARS);
    check("set_wins_req", bus.car_req, 1);
    // Car leaves and returns without being serviced
    bus.sensor_raw = 1'b0;
    step(8);
    check("leave_state", bus.sensor_state, NO_CARS);
    check("leave_req", bus.car_req, 1);
    bus.sensor_raw = 1'b1;
    step(8);
    check("return_state", bus.sensor_state, CARS);
    check("return_req", bus.car_req, 1);
    bus.req_ack = 1'b1;
    step(1);
    check("ack2_clear", bus.car_req, 0);
    step(1);
    bus.req_ack = 1'b0;
    check("ack_idle_noeffect", bus.car_req, 0);

    // Enable dropped mid-confirmation
    do_reset();
    bus.sensor_raw = 1'b1;
    step(4);
    bus.enable = 1'b0;
    step(1);
    check("dis_state", bus.sensor_state, NO_CARS);
    check("dis_glitch", bus.glitch_cnt, 0);
    step(2);
    bus.enable = 1'b1;
    step(3);
    check("reen_edge3", bus.sensor_state, NO_CARS);
    step(1);
    check("reen_edge4_state", bus.sensor_state, CARS);
    check("reen_edge4_req", bus.car_req, 1);
    check("reen_glitch", bus.glitch_cnt, 0);
    bus.enable = 1'b0;
    step(1);
    check("dis_clears_req", bus.car_req, 0);
    check("dis_clears_state", bus.sensor_state, NO_CARS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
